// File: rtl/bit_counter_pkg.sv
// Shared types for the parametrised bit counter: count modes, FSM states
// and the decode of the raw 2-bit mode input.
package bit_counter_pkg;

    typedef enum logic [1:0] {
        MODE_ONES  = 2'b00,
        MODE_ZEROS = 2'b01,
        MODE_TZ    = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    // The unused encoding 2'b11 behaves exactly like a ones count.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_ZEROS;
            2'b10:   return MODE_TZ;
            default: return MODE_ONES;
        endcase
    endfunction

endpackage

// File: rtl/bit_counter_param_datapath.sv
// Shift/count datapath: holds the working operand and the running count.
// The controller decides when to load, shift and increment; the datapath
// only reports whether the operand is empty and what its LSB is.
module bit_counter_param_datapath #(
    parameter int WIDTH = 8,
    localparam int RW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             incr,
    input  logic             inv,
    input  logic [WIDTH-1:0] a,
    output logic             a_eq_0,
    output logic             a0,
    output logic [RW-1:0]    result
);

    logic [WIDTH-1:0] a_reg_q, a_reg_d;
    logic [RW-1:0]    result_q, result_d;

    // Next operand/count: load wins over shift; otherwise both are held.
    always_comb begin
        a_reg_d  = a_reg_q;
        result_d = result_q;
        if (load) begin
            a_reg_d  = inv ? ~a : a;
            result_d = '0;
        end else if (shift) begin
            a_reg_d = a_reg_q >> 1;
            if (incr) begin
                result_d = result_q + RW'(1);
            end
        end
    end

    // Operand and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg_q  <= '0;
            result_q <= '0;
        end else begin
            a_reg_q  <= a_reg_d;
            result_q <= result_d;
        end
    end

    assign a_eq_0 = (a_reg_q == '0);
    assign a0     = a_reg_q[0];
    assign result = result_q;

endmodule

// File: rtl/bit_counter_param.sv
// Self-sequencing bit counter: counts ones, zeros or trailing zeros of a
// WIDTH-bit operand after a start handshake. The first cycle in S_SHIFT is
// an arm cycle that lets the freshly loaded operand settle before its
// status flags steer the count, which fixes the latency at (steps + 2).
module bit_counter_param
    import bit_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int RW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic [RW-1:0]    result
);

    state_t state_q, state_d;
    mode_t  mode_q, mode_d;
    logic   arm_q, arm_d;

    logic   load, shift, incr, inv;
    logic   a_eq_0, a0;
    mode_t  mode_in;

    assign mode_in = decode_mode(mode);

    // Next-state and datapath control; all controls default to idle.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        arm_d   = arm_q;
        load    = 1'b0;
        shift   = 1'b0;
        incr    = 1'b0;
        inv     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    inv     = (mode_in != MODE_ONES);
                    mode_d  = mode_in;
                    arm_d   = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (arm_q) begin
                    arm_d = 1'b0;
                end else if (mode_q == MODE_TZ) begin
                    // Trailing zeros of A are trailing ones of ~A.
                    if (!a0) begin
                        state_d = S_DONE;
                    end else begin
                        shift = 1'b1;
                        incr  = 1'b1;
                    end
                end else begin
                    if (a_eq_0) begin
                        state_d = S_DONE;
                    end else begin
                        shift = 1'b1;
                        incr  = a0;
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_ONES;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            arm_q   <= arm_d;
        end
    end

    bit_counter_param_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .shift  (shift),
        .incr   (incr),
        .inv    (inv),
        .a      (A),
        .a_eq_0 (a_eq_0),
        .a0     (a0),
        .result (result)
    );

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_bit_counter_param.sv
// Bench for bit_counter_param: a WIDTH=8 and a WIDTH=16 instance driven
// with directed and random operations; a monitor per instance checks each
// completed count and its latency against a behavioural model.
module tb_bit_counter_param;

    typedef struct {
        int res;
        int lat;
        int load_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;

    logic        start8 = 1'b0, start16 = 1'b0;
    logic [1:0]  mode8 = 2'b00, mode16 = 2'b00;
    logic [7:0]  a8 = '0;
    logic [15:0] a16 = '0;
    logic        busy8, done8, busy16, done16;
    logic [3:0]  res8;
    logic [4:0]  res16;

    int tests = 0;
    int fails = 0;
    exp_t q8[$];
    exp_t q16[$];

    bit_counter_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst), .start(start8), .mode(mode8), .A(a8),
        .busy(busy8), .done(done8), .result(res8)
    );

    bit_counter_param #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(rst), .start(start16), .mode(mode16), .A(a16),
        .busy(busy16), .done(done16), .result(res16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: counts straight from the operand value.
    function automatic int model_res(input int w, input logic [1:0] m, input logic [15:0] a);
        int ones = 0;
        int tz = 0;
        bit seen = 0;
        for (int i = 0; i < w; i++) begin
            if (a[i]) begin
                ones++;
                seen = 1;
            end else if (!seen) begin
                tz++;
            end
        end
        if (m == 2'b01) return w - ones;
        if (m == 2'b10) return tz;
        return ones;
    endfunction

    function automatic int model_lat(input int w, input logic [1:0] m, input logic [15:0] a);
        int p = 0;
        if (m == 2'b10) return model_res(w, m, a) + 2;
        for (int i = 0; i < w; i++) begin
            if ((m == 2'b01) ? !a[i] : a[i]) p = i + 1;
        end
        return p + 2;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done8 : done16;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy8 : busy16;
    endfunction

    function automatic int get_res(input int sel);
        return (sel == 0) ? int'(res8) : int'(res16);
    endfunction

    task automatic drive(input int sel, input logic s, input logic [1:0] m, input logic [15:0] a);
        if (sel == 0) begin
            start8 = s; mode8 = m; a8 = a[7:0];
        end else begin
            start16 = s; mode16 = m; a16 = a;
        end
    endtask

    task automatic set_start(input int sel, input logic s);
        if (sel == 0) start8 = s; else start16 = s;
    endtask

    // One full operation: load, optional disturbance, wait for done,
    // handshake checks. Result/latency are checked by the monitor.
    task automatic run_op(input int sel, input logic [1:0] m, input logic [15:0] a,
                          input bit hold_thru, input bit disturb);
        int   w;
        int   n;
        exp_t e;
        w = (sel == 0) ? 8 : 16;
        e.res = model_res(w, m, a);
        e.lat = model_lat(w, m, a);
        @(negedge clk);
        drive(sel, 1'b1, m, a);
        e.load_cyc = cyc + 1;
        if (sel == 0) q8.push_back(e); else q16.push_back(e);
        @(negedge clk);
        if (!hold_thru) set_start(sel, 1'b0);
        if (disturb) begin
            if (sel == 0) begin
                a8 = 8'($urandom); mode8 = 2'($urandom);
            end else begin
                a16 = 16'($urandom); mode16 = 2'($urandom);
            end
        end
        n = 0;
        while (!get_done(sel) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!get_done(sel)) begin
            check("done_timeout", 0, 1);
            if (sel == 0) q8.delete(); else q16.delete();
            set_start(sel, 1'b0);
            return;
        end
        if (hold_thru) begin
            repeat (3) @(negedge clk);
            check("hold_done", int'(get_done(sel)), 1);
            check("hold_busy", int'(get_busy(sel)), 0);
            check("hold_result", get_res(sel), e.res);
            set_start(sel, 1'b0);
        end
        @(negedge clk);
        check("done_fall", int'(get_done(sel)), 0);
        check("result_held", get_res(sel), e.res);
    endtask

    // Monitor, 8-bit instance.
    int  run8 = 0;
    logic dprev8 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done8 && !dprev8) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_done", 1, 0);
            end else begin
                e = q8.pop_front();
                check("w8_result", int'(res8), e.res);
                check("w8_latency", cyc - e.load_cyc, e.lat);
                check("w8_busy_cycles", run8, e.lat);
                check("w8_busy_at_done", int'(busy8), 0);
            end
        end
        run8   = busy8 ? run8 + 1 : 0;
        dprev8 = done8;
    end

    // Monitor, 16-bit instance.
    int  run16 = 0;
    logic dprev16 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done16 && !dprev16) begin
            if (q16.size() == 0) begin
                check("w16_unexpected_done", 1, 0);
            end else begin
                e = q16.pop_front();
                check("w16_result", int'(res16), e.res);
                check("w16_latency", cyc - e.load_cyc, e.lat);
                check("w16_busy_cycles", run16, e.lat);
                check("w16_busy_at_done", int'(busy16), 0);
            end
        end
        run16   = busy16 ? run16 + 1 : 0;
        dprev16 = done16;
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_res8", int'(res8), 0);
        check("rst_busy8", int'(busy8), 0);
        check("rst_done8", int'(done8), 0);
        check("rst_res16", int'(res16), 0);
        check("rst_busy16", int'(busy16), 0);
        check("rst_done16", int'(done16), 0);
        rst = 1'b0;

        run_op(0, 2'b00, 16'h00B2, 0, 0);
        run_op(0, 2'b00, 16'h0000, 0, 0);
        run_op(0, 2'b01, 16'h0000, 0, 0);
        run_op(0, 2'b01, 16'h00F0, 0, 0);
        run_op(0, 2'b10, 16'h0028, 0, 0);
        run_op(0, 2'b10, 16'h0000, 0, 0);
        run_op(0, 2'b10, 16'h0001, 0, 0);
        run_op(0, 2'b00, 16'h005A, 1, 0);
        run_op(0, 2'b01, 16'h0013, 0, 1);

        // Reset in the middle of a count discards it.
        @(negedge clk);
        drive(0, 1'b1, 2'b00, 16'h00FF);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", int'(busy8), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_res", int'(res8), 0);
        check("mid_rst_busy", int'(busy8), 0);
        check("mid_rst_done", int'(done8), 0);
        rst = 1'b0;
        run_op(0, 2'b00, 16'h00FF, 0, 0);

        run_op(1, 2'b00, 16'h8001, 0, 0);
        run_op(1, 2'b11, 16'h0003, 0, 0);
        run_op(1, 2'b10, 16'h0000, 1, 1);

        for (int i = 0; i < 24; i++) begin
            run_op(i % 2, 2'($urandom), 16'($urandom),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end

        repeat (4) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q16_drained", q16.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
